// File: rtl/pdp8_pkg.sv
// pdp8_pkg -- shared definitions for the instruction fetch sequencer.
//
// Contents:
//   ADDR_W_DEF, DATA_W_DEF  default address/PC and data widths
//   WAIT_MAX_DEF            default memAck wait budget in REQ cycles
//   state_t                 fetch FSM state encoding
//
// Build option: SINGLE_STEP_EN adds the PAUSE state used by single-step mode.

package pdp8_pkg;

   localparam int ADDR_W_DEF   = 12;
   localparam int DATA_W_DEF   = 12;
   localparam int WAIT_MAX_DEF = 15;

`ifdef SINGLE_STEP_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      ERR    = 3'd4,
      PAUSE  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      ERR    = 3'd4
   } state_t;
`endif

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer -- memAck wait counter for the REQ state.
//
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset
//   clr           restart the count (issued as the fetch launches)
//   en            high while the sequencer is in REQ
//   expired       high during the WAIT_MAX-th consecutive REQ cycle; if
//                 memAck is still absent at that edge the fetch times out

module fetch_timer
   import pdp8_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] count;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   // count holds the number of REQ cycles already completed, so the
   // WAIT_MAX-th cycle is the one where it equals WAIT_MAX-1.
   assign expired = en && (count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq -- instruction fetch sequencer: reads one word at PC, strobes it
// into the instruction register, then advances PC.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   start, pcLoad, pcIn fetch request / PC load (sampled only in IDLE)
//   errClr              clears busErr and leaves ERR
//   memAck, memData     memory read response
//   memRd, memAddr      memory read request; memAddr always equals PC
//   busData, ckFetch    fetched word and its one-cycle capture strobe
//   done                one-cycle pulse as the fetch completes
//   busErr              sticky memory-timeout flag
//   pc                  program counter
//   fsm_state           current FSM state, for observation
//   stepMode, stepGo    single-step controls (SINGLE_STEP_EN builds only)
//
// Build option: SINGLE_STEP_EN adds stepMode/stepGo and the PAUSE state.
//
// Memory handshake: memRd rises on the edge that leaves IDLE for REQ and
// stays high until the edge that captures memData (memAck=1 in REQ) or the
// edge that times out. memAck is only looked at in REQ; memData only matters
// on the capturing edge.

module fetch_seq
   import pdp8_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              start,
   input  logic              pcLoad,
   input  logic [ADDR_W-1:0] pcIn,
   input  logic              errClr,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memData,
`ifdef SINGLE_STEP_EN
   input  logic              stepMode,
   input  logic              stepGo,
`endif
   output logic              memRd,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] busData,
   output logic              ckFetch,
   output logic              done,
   output logic              busErr,
   output logic [ADDR_W-1:0] pc,
   output state_t            fsm_state
);

   state_t state;
   logic   timer_clr;
   logic   timer_en;
   logic   expired;

   assign timer_clr = (state == IDLE) && start && !pcLoad;
   assign timer_en  = (state == REQ);

   fetch_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (expired)
   );

   assign memAddr   = pc;
   assign fsm_state = state;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         pc      <= '0;
         busData <= '0;
         memRd   <= 1'b0;
         ckFetch <= 1'b0;
         done    <= 1'b0;
         busErr  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A load wins over a simultaneous start; that start is dropped.
               if (pcLoad) begin
                  pc <= pcIn;
               end else if (start) begin
                  memRd <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               // An ack on the final allowed cycle still completes the fetch.
               if (memAck) begin
                  busData <= memData;
                  memRd   <= 1'b0;
                  ckFetch <= 1'b1;
                  state   <= STROBE;
               end else if (expired) begin
                  memRd  <= 1'b0;
                  busErr <= 1'b1;
                  state  <= ERR;
               end
            end
            STROBE: begin
               ckFetch <= 1'b0;
               pc      <= pc + 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
`ifdef SINGLE_STEP_EN
               if (stepMode) begin
                  state <= PAUSE;
               end else begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
`else
               done  <= 1'b1;
               state <= IDLE;
`endif
            end
            ERR: begin
               if (errClr) begin
                  busErr <= 1'b0;
                  state  <= IDLE;
               end
            end
`ifdef SINGLE_STEP_EN
            PAUSE: begin
               if (stepGo) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq -- self-checking bench for fetch_seq.
// A driver issues fetches against a small memory responder with a chosen ack
// latency; each fetch's expected outcome (word, PC before fetch, or timeout)
// is pushed to exp_q, and a monitor pops and compares on ckFetch/done/busErr.

module tb_fetch_seq;
   import pdp8_pkg::*;

   localparam int AW = 12;
   localparam int DW = 12;
   localparam int WM = 15;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          start = 1'b0;
   logic          pcLoad = 1'b0;
   logic [AW-1:0] pcIn = '0;
   logic          errClr = 1'b0;
   logic          memAck = 1'b0;
   logic [DW-1:0] memData = '0;
`ifdef SINGLE_STEP_EN
   logic          stepMode = 1'b0;
   logic          stepGo = 1'b0;
`endif
   logic          memRd;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] busData;
   logic          ckFetch;
   logic          done;
   logic          busErr;
   logic [AW-1:0] pc;
   state_t        fsm_state;

   fetch_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .start     (start),
      .pcLoad    (pcLoad),
      .pcIn      (pcIn),
      .errClr    (errClr),
      .memAck    (memAck),
      .memData   (memData),
`ifdef SINGLE_STEP_EN
      .stepMode  (stepMode),
      .stepGo    (stepGo),
`endif
      .memRd     (memRd),
      .memAddr   (memAddr),
      .busData   (busData),
      .ckFetch   (ckFetch),
      .done      (done),
      .busErr    (busErr),
      .pc        (pc),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   // {timeout_expected, pc_before_fetch[11:0], word[11:0]}
   logic [24:0] exp_q[$];
   int model_pc = 0;
   int ok_fetches = 0;
   int ck_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   logic prev_ck = 1'b0;
   logic prev_done = 1'b0;
   logic prev_err = 1'b0;

   always @(negedge CLK) begin
      logic [24:0] e;
      if (!RESET_N) begin
         prev_ck = 1'b0;
         prev_done = 1'b0;
         prev_err = 1'b0;
      end else begin
         if (ckFetch) begin
            ck_count++;
            check("ck_one_cycle", 32'(prev_ck), 0);
            if (exp_q.size() == 0) begin
               check("ck_unexpected", 1, 0);
            end else begin
               e = exp_q[0];
               check("ck_kind", 32'(e[24]), 0);
               check("ck_busData", 32'(busData), 32'(e[11:0]));
               check("ck_pc", 32'(pc), 32'(e[23:12]));
            end
         end
         if (done) begin
            check("done_one_cycle", 32'(prev_done), 0);
            if (exp_q.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("done_kind", 32'(e[24]), 0);
               check("done_pc", 32'(pc), 32'((int'(e[23:12]) + 1) % (1 << AW)));
               check("done_busData", 32'(busData), 32'(e[11:0]));
            end
         end
         if (busErr && !prev_err) begin
            if (exp_q.size() == 0) begin
               check("err_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("err_kind", 32'(e[24]), 1);
               check("err_pc", 32'(pc), 32'(e[23:12]));
               check("err_memRd", 32'(memRd), 0);
            end
         end
         prev_ck = ckFetch;
         prev_done = done;
         prev_err = busErr;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_pc(input int v);
      @(negedge CLK);
      pcLoad = 1'b1;
      pcIn = AW'(v);
      @(negedge CLK);
      pcLoad = 1'b0;
      model_pc = v % (1 << AW);
   endtask

   task automatic wait_idle(input string name);
      for (int n = 0; n < 40 && fsm_state != IDLE; n++) @(negedge CLK);
      check(name, 32'(fsm_state), 32'(IDLE));
   endtask

   // One fetch whose memory answers after lat idle REQ cycles; lat >= WM
   // means no answer within the budget, so a timeout is expected.
   task automatic fetch(input int lat, input logic [DW-1:0] word, input bit poke_start);
      bit will_err;
      will_err = (lat >= WM);
      exp_q.push_back({will_err, AW'(model_pc), word});
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 0; i < WM + 2; i++) begin
         memAck = (i == lat);
         memData = (i == lat) ? word : DW'($urandom);
         start = (poke_start && i == 1);
         @(negedge CLK);
      end
      memAck = 1'b0;
      start = 1'b0;
      if (will_err) begin
         check("err_flag", 32'(busErr), 1);
         // start/pcLoad must be ignored while in ERR
         start = 1'b1;
         pcLoad = 1'b1;
         pcIn = AW'($urandom);
         @(negedge CLK);
         start = 1'b0;
         pcLoad = 1'b0;
         check("err_ignore_pc", 32'(pc), 32'(model_pc));
         check("err_ignore_memRd", 32'(memRd), 0);
         errClr = 1'b1;
         @(negedge CLK);
         errClr = 1'b0;
         check("errclr_busErr", 32'(busErr), 0);
      end else begin
         model_pc = (model_pc + 1) % (1 << AW);
         ok_fetches++;
      end
      wait_idle("fetch_idle");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat_n;
      int err_n;
      int ck0;
      int v;

      // Reset values
      repeat (2) @(negedge CLK);
      check("rst_pc", 32'(pc), 0);
      check("rst_memAddr", 32'(memAddr), 0);
      check("rst_busData", 32'(busData), 0);
      check("rst_memRd", 32'(memRd), 0);
      check("rst_ckFetch", 32'(ckFetch), 0);
      check("rst_done", 32'(done), 0);
      check("rst_busErr", 32'(busErr), 0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      RESET_N = 1'b1;

      // Basic fetch with memAck already high: latency and results
      load_pc('o200);
      check("load_memAddr", 32'(memAddr), 'o200);
      exp_q.push_back({1'b0, 12'o0200, 12'o7402});
      memAck = 1'b1;
      memData = 12'o7402;
      ck0 = ck_count;
      lat_n = 0;
      @(negedge CLK);
      start = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge CLK);
         #1;
         start = 1'b0;
         if (done && lat_n == 0) lat_n = n;
      end
      memAck = 1'b0;
      model_pc = 'o201;
      ok_fetches++;
      check("latency", 32'(lat_n), 4);
      check("basic_pc", 32'(pc), 'o201);
      check("basic_ck_count", 32'(ck_count - ck0), 1);

      // PC wrap
      load_pc('o7777);
      fetch(3, DW'($urandom), 1'b0);
      check("wrap_pc", 32'(pc), 0);

      // Timeout: memAck held low
      load_pc('o1234);
      exp_q.push_back({1'b1, 12'o1234, 12'h000});
      ck0 = ck_count;
      err_n = 0;
      @(negedge CLK);
      start = 1'b1;
      for (int n = 1; n <= 21; n++) begin
         @(posedge CLK);
         #1;
         start = 1'b0;
         if (busErr && err_n == 0) err_n = n;
      end
      check("timeout_cycle", 32'(err_n), WM + 1);
      check("timeout_memRd", 32'(memRd), 0);
      check("timeout_no_ck", 32'(ck_count - ck0), 0);
      check("timeout_pc", 32'(pc), 'o1234);
      @(negedge CLK);
      errClr = 1'b1;
      @(negedge CLK);
      errClr = 1'b0;
      check("timeout_clr_state", 32'(fsm_state), 32'(IDLE));
      check("timeout_clr_busErr", 32'(busErr), 0);

      // pcLoad and start together: load only
      v = int'($urandom_range(0, (1 << AW) - 1));
      @(negedge CLK);
      pcLoad = 1'b1;
      start = 1'b1;
      pcIn = AW'(v);
      @(negedge CLK);
      pcLoad = 1'b0;
      start = 1'b0;
      model_pc = v;
      check("both_pc", 32'(pc), 32'(v));
      check("both_memRd", 32'(memRd), 0);
      @(negedge CLK);
      check("both_state", 32'(fsm_state), 32'(IDLE));

      // start during REQ is ignored; boundary latencies
      fetch(5, DW'($urandom), 1'b1);
      repeat (3) begin
         @(negedge CLK);
         check("no_refetch_memRd", 32'(memRd), 0);
      end
      fetch(WM - 1, DW'($urandom), 1'b0);
      fetch(WM, DW'($urandom), 1'b0);

      // Reset during REQ
      load_pc('o0456);
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      @(negedge CLK);
      check("pre_rst_memRd", 32'(memRd), 1);
      ck0 = ck_count;
      #2;
      RESET_N = 1'b0;
      #1;
      check("midrst_memRd", 32'(memRd), 0);
      check("midrst_pc", 32'(pc), 0);
      check("midrst_ckFetch", 32'(ckFetch), 0);
      check("midrst_state", 32'(fsm_state), 32'(IDLE));
      memAck = 1'b1;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      memAck = 1'b0;
      model_pc = 0;
      repeat (3) @(negedge CLK);
      check("midrst_no_ck", 32'(ck_count - ck0), 0);
      check("midrst_busData", 32'(busData), 0);

`ifdef SINGLE_STEP_EN
      // Single-step: no done until stepGo, then exactly one
      begin
         int done_n;
         stepMode = 1'b1;
         exp_q.push_back({1'b0, AW'(model_pc), 12'o5252});
         memAck = 1'b1;
         memData = 12'o5252;
         done_n = 0;
         @(negedge CLK);
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         repeat (8) begin
            @(negedge CLK);
            if (done) done_n++;
         end
         memAck = 1'b0;
         check("step_no_done", 32'(done_n), 0);
         check("step_pause", 32'(fsm_state), 32'(PAUSE));
         stepGo = 1'b1;
         @(negedge CLK);
         stepGo = 1'b0;
         repeat (4) begin
            if (done) done_n++;
            @(negedge CLK);
         end
         check("step_one_done", 32'(done_n), 1);
         stepMode = 1'b0;
         model_pc = (model_pc + 1) % (1 << AW);
         ok_fetches++;
      end
`endif

      // Randomized fetches
      for (int k = 0; k < 25; k++) begin
         int lat;
         if ($urandom_range(0, 3) == 0) load_pc(int'($urandom_range(0, (1 << AW) - 1)));
         lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(WM, WM + 5))
                                            : int'($urandom_range(0, WM - 1));
         fetch(lat, DW'($urandom), bit'($urandom_range(0, 1)));
         check("rand_pc", 32'(pc), 32'(model_pc));
      end

      repeat (4) @(negedge CLK);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("ck_total", 32'(ck_count), 32'(ok_fetches));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset: ports CLK and RESET_N.
REQ-002 Parameter ADDR_W, default 12, SHALL set the memory address and PC width.
REQ-003 Parameter DATA_W, default 12, SHALL set the memory and bus data width.
REQ-004 Parameter WAIT_MAX, default 15, SHALL set the maximum number of cycles spent waiting for memAck before a bus error.
REQ-005 CLK  in  1  system clock, all state changes on its rising edge.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request one instruction fetch, sampled only in IDLE.
REQ-008 pcLoad  in  1  load pcIn into PC, sampled only in IDLE.
REQ-009 pcIn  in  ADDR_W  new PC value.
REQ-010 errClr  in  1  clear sticky busErr and leave ERR.
REQ-011 memAck  in  1  memory read data valid.
REQ-012 memData  in  DATA_W  memory read data.
REQ-013 memRd  out  1  memory read request, registered.
REQ-014 memAddr  out  ADDR_W  equals PC at all times.
REQ-015 busData  out  DATA_W  fetched word presented to the instruction register.
REQ-016 ckFetch  out  1  fetch strobe; the instruction register captures busData on its rising edge.
REQ-017 done  out  1  one-cycle pulse at fetch completion.
REQ-018 busErr  out  1  sticky memory-timeout flag.
REQ-019 pc  out  ADDR_W  current program counter.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, STROBE, HOLD and ERR (plus PAUSE when REQ-031 applies).
REQ-021 IDLE: pcLoad=1 SHALL load PC from pcIn and remain in IDLE; pcLoad has priority over a simultaneous start, which is then dropped.
REQ-022 IDLE: start=1 with pcLoad=0 SHALL set memRd=1 on the next edge, clear the wait counter and enter REQ.
REQ-023 REQ: at an edge with memAck=1, the block SHALL set busData<=memData, memRd<=0 and ckFetch<=1, then enter STROBE.
REQ-024 STROBE: ckFetch SHALL be high for exactly one cycle; the next edge sets ckFetch<=0 and PC<=PC+1 modulo 2^ADDR_W (4095 wraps to 0), then enters HOLD.
REQ-025 busData SHALL hold its value from STROBE entry until the next memAck capture.
REQ-026 HOLD: the next edge SHALL pulse done=1 for one cycle and return to IDLE; minimum start-to-done latency is 4 cycles with memAck already asserted.
REQ-027 REQ: when the wait counter reaches WAIT_MAX without memAck, the block SHALL set memRd<=0 and busErr<=1 and enter ERR; PC is unchanged and ckFetch is not pulsed.
REQ-028 ERR: start and pcLoad SHALL be ignored; errClr=1 SHALL clear busErr and enter IDLE.
REQ-029 start, pcLoad and memAck outside the states named above SHALL be ignored.

Reset
REQ-030 RESET_N=0 SHALL, asynchronously, force state=IDLE, PC=0, busData=0, and memRd, ckFetch, done and busErr to 0; a reset mid-fetch aborts the fetch with no ckFetch pulse.

Configuration
REQ-031 With SINGLE_STEP_EN defined, the block SHALL add the inputs stepMode and stepGo; when stepMode=1, HOLD goes to PAUSE, and PAUSE waits for stepGo=1, then pulses done and enters IDLE.
REQ-032 Without SINGLE_STEP_EN, the stepMode and stepGo ports and the PAUSE state SHALL be absent, and behaviour SHALL equal stepMode=0.

Structure
REQ-033 The state encodings and the default widths SHALL live in the shared package pdp8_pkg.
REQ-034 The REQ wait counter with its WAIT_MAX compare SHALL be the sub-module fetch_timer.

Verification
REQ-035 Reset, then pcLoad with pcIn=12'o0200, then start with memAck tied high and memData=12'o7402: memAddr=0200, one ckFetch pulse with busData=7402, pc=0201, done 4 cycles after start.
REQ-036 PC=12'o7777 and one fetch: pc wraps to 0000.
REQ-037 memAck held low for 20 cycles with WAIT_MAX=15: busErr=1 after 15 REQ cycles, memRd=0, no ckFetch, pc unchanged; errClr then returns the FSM to IDLE.
REQ-038 pcLoad and start asserted together: PC loads and no memRd; a start asserted during REQ is ignored.
REQ-039 RESET_N low during REQ: memRd=0 immediately, pc=0, and no ckFetch pulse.
REQ-040 With SINGLE_STEP_EN and stepMode=1: no done until stepGo, then exactly one done pulse.
